// File: rtl/result_collector_pkg.sv
// Shared constants and types for the result collector.
package result_collector_pkg;

  localparam int DEF_ROW_W          = 32;
  localparam int DEF_NUM_ROWS       = 10;
  localparam int DEF_TIMEOUT_CYCLES = 2048;
  localparam int ROW_IDX_W          = 4;
  localparam int TIMER_W            = 12;
  localparam int BANK_DEPTH         = 2 ** ROW_IDX_W;

  // Most-negative 32-bit signed value; argmax starting point.
  localparam logic [DEF_ROW_W-1:0] MIN_SIGNED = 32'h8000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_ADVANCE,
    ST_FINISH
  } collector_state_t;

endpackage

// File: rtl/result_collector_argmax_tracker.sv
// Running signed argmax: keeps the largest value seen and the row that produced it.
module argmax_tracker
  import result_collector_pkg::*;
#(
  parameter int W = DEF_ROW_W
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 clear_i,
  input  logic                 update_i,
  input  logic                 force_i,
  input  logic [ROW_IDX_W-1:0] idx_i,
  input  logic [W-1:0]         value_i,
  output logic [ROW_IDX_W-1:0] digit_o,
  output logic [W-1:0]         max_o
);

  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  logic [ROW_IDX_W-1:0] digit_q;
  logic [W-1:0]         max_q;
  logic                 take_d;

  // Strictly greater wins so ties keep the lower index; force loads the first row unconditionally.
  always_comb begin
    take_d = update_i && (force_i || ($signed(value_i) > $signed(max_q)));
  end

  // Max/index registers with clear on sweep start.
  always_ff @(posedge clk) begin
    if (!n_rst || clear_i) begin
      digit_q <= '0;
      max_q   <= MIN_VAL;
    end else if (take_d) begin
      digit_q <= idx_i;
      max_q   <= value_i;
    end
  end

  assign digit_o = digit_q;
  assign max_o   = max_q;

endmodule

// File: rtl/result_collector.sv
// Sequences multiplier rows, banks each row result and tracks the winning class.
module result_collector
  import result_collector_pkg::*;
#(
  parameter int ROW_W          = DEF_ROW_W,
  parameter int NUM_ROWS       = DEF_NUM_ROWS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  output logic [ROW_IDX_W-1:0] row_select,
  output logic                 begin_mult,
  input  logic                 w_result_ena,
  input  logic                 done_row,
  input  logic [ROW_W-1:0]     row_result,
  input  logic                 overflow,
  output logic                 busy,
  output logic                 done,
  output logic [ROW_IDX_W-1:0] digit,
  output logic [ROW_W-1:0]     max_value,
  output logic                 overflow_any,
  output logic                 timeout_err,
  input  logic [ROW_IDX_W-1:0] rd_addr,
  output logic [ROW_W-1:0]     rd_data
);

  localparam logic [TIMER_W-1:0]   TMO_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ROW_IDX_W-1:0] ROW_LAST = ROW_IDX_W'(NUM_ROWS - 1);

  collector_state_t     state_q;
  logic [ROW_IDX_W-1:0] row_q;
  logic [TIMER_W-1:0]   timer_q;
  logic                 begin_mult_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 ovf_any_q;
  logic                 tmo_err_q;
  logic [ROW_W-1:0]     bank_q [BANK_DEPTH];

  logic                 sweep_start_d;
  logic                 strobe_d;
  logic                 timeout_d;
  logic                 bank_we_d;
  logic [ROW_W-1:0]     bank_wdata_d;

  // done_row is only a companion of the strobe; the row is closed by w_result_ena alone.
  // A strobe in the timeout cycle takes priority, so the timeout is qualified by its absence.
  always_comb begin
    sweep_start_d = (state_q == ST_IDLE) && start;
    strobe_d      = (state_q == ST_WAIT) && w_result_ena;
    timeout_d     = (state_q == ST_WAIT) && !w_result_ena && (timer_q >= TMO_LAST);
    bank_we_d     = strobe_d || timeout_d;
    bank_wdata_d  = strobe_d ? row_result : '0;
  end

  // Sweep sequencer: begin_mult/done are registered one-cycle pulses, busy spans start..FINISH.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      timer_q      <= '0;
      begin_mult_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ovf_any_q    <= 1'b0;
      tmo_err_q    <= 1'b0;
    end else begin
      begin_mult_q <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            row_q        <= '0;
            timer_q      <= '0;
            ovf_any_q    <= 1'b0;
            tmo_err_q    <= 1'b0;
            busy_q       <= 1'b1;
            begin_mult_q <= 1'b1;
            state_q      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          timer_q <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (timer_q != '1) begin
            timer_q <= timer_q + 1'b1;
          end
          if (w_result_ena) begin
            ovf_any_q <= ovf_any_q | overflow;
            state_q   <= ST_ADVANCE;
          end else if (timeout_d) begin
            tmo_err_q <= 1'b1;
            state_q   <= ST_ADVANCE;
          end
        end
        ST_ADVANCE: begin
          if (row_q == ROW_LAST) begin
            done_q  <= 1'b1;
            state_q <= ST_FINISH;
          end else begin
            row_q        <= row_q + 1'b1;
            begin_mult_q <= 1'b1;
            state_q      <= ST_ISSUE;
          end
        end
        ST_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // One register per bank entry; entries beyond NUM_ROWS never get written and stay zero.
  for (genvar gi = 0; gi < BANK_DEPTH; gi++) begin : g_bank
    always_ff @(posedge clk) begin
      if (!n_rst) begin
        bank_q[gi] <= '0;
      end else if (bank_we_d && (gi < NUM_ROWS) && (row_q == ROW_IDX_W'(gi))) begin
        bank_q[gi] <= bank_wdata_d;
      end
    end
  end

  // Host read port; out-of-range addresses read as zero.
  always_comb begin
    rd_data = '0;
    if ({1'b0, rd_addr} < (ROW_IDX_W + 1)'(NUM_ROWS)) begin
      rd_data = bank_q[rd_addr];
    end
  end

  argmax_tracker #(
    .W(ROW_W)
  ) u_argmax (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear_i (sweep_start_d),
    .update_i(strobe_d),
    .force_i (row_q == '0),
    .idx_i   (row_q),
    .value_i (row_result),
    .digit_o (digit),
    .max_o   (max_value)
  );

  assign row_select   = row_q;
  assign begin_mult   = begin_mult_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign overflow_any = ovf_any_q;
  assign timeout_err  = tmo_err_q;

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector with a behavioural multiplier responder.
module tb_result_collector;
  import result_collector_pkg::*;

  localparam int NR  = 10;
  localparam int TMO = 2048;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start = 1'b0;
  logic        w_result_ena = 1'b0;
  logic        done_row = 1'b0;
  logic        overflow = 1'b0;
  logic [31:0] row_result = '0;
  logic [3:0]  rd_addr = '0;

  logic [3:0]  row_select;
  logic        begin_mult;
  logic        busy;
  logic        done;
  logic [3:0]  digit;
  logic [31:0] max_value;
  logic        overflow_any;
  logic        timeout_err;
  logic [31:0] rd_data;

  result_collector #(
    .ROW_W(32), .NUM_ROWS(NR), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .n_rst(n_rst), .start(start),
    .row_select(row_select), .begin_mult(begin_mult),
    .w_result_ena(w_result_ena), .done_row(done_row),
    .row_result(row_result), .overflow(overflow),
    .busy(busy), .done(done), .digit(digit), .max_value(max_value),
    .overflow_any(overflow_any), .timeout_err(timeout_err),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NR-1:0][31:0] vals;
    logic [NR-1:0]       ovf;
    logic [NR-1:0]       skip;
    logic [3:0]          exp_digit;
    logic [31:0]         exp_max;
    logic                exp_ovf;
    logic                exp_tmo;
  } vec_t;

  vec_t vecs [4];

  // Responder controls (written by main thread only).
  logic [NR-1:0][31:0] r_vals;
  logic [NR-1:0]       r_ovf;
  logic [NR-1:0]       r_skip;
  int                  latency = 20;
  bit                  noise_en = 1'b0;
  int                  poke_req = 0;
  int                  poke_ack = 0;

  int checks = 0;
  int errors = 0;

  // Monitor state (written by monitor only).
  int         bm_cnt = 0;
  int         done_cnt = 0;
  logic [3:0] bm_log [256];

  always @(negedge clk) begin
    if (begin_mult) begin
      if (bm_cnt < 256) bm_log[bm_cnt] = row_select;
      bm_cnt++;
    end
    if (done) done_cnt++;
  end

  // Multiplier responder: answers each begin_mult after `latency` cycles unless the row is skipped.
  initial begin
    int r;
    forever begin
      @(posedge clk); #1;
      if (poke_req != poke_ack) begin
        w_result_ena = 1'b1; overflow = 1'b1; row_result = 32'h1234_5678;
        repeat (3) begin @(posedge clk); #1; end
        w_result_ena = 1'b0; overflow = 1'b0; row_result = '0;
        poke_ack = poke_req;
      end else if (begin_mult) begin
        r = int'(row_select);
        for (int c = 0; c < latency; c++) begin
          done_row = noise_en && (c % 5 == 2);
          @(posedge clk); #1;
        end
        done_row = 1'b0;
        if (!r_skip[r]) begin
          w_result_ena = 1'b1; done_row = 1'b1;
          row_result = r_vals[r]; overflow = r_ovf[r];
          @(posedge clk); #1;
          w_result_ena = 1'b0; done_row = 1'b0; overflow = 1'b0; row_result = '0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_row_select"}, 32'(row_select), 32'd0);
    chk({tag, "_begin_mult"}, 32'(begin_mult), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_digit"}, 32'(digit), 32'd0);
    chk({tag, "_max_value"}, max_value, MIN_SIGNED);
    chk({tag, "_overflow_any"}, 32'(overflow_any), 32'd0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    rd_addr = 4'd0; @(negedge clk);
    chk({tag, "_bank0"}, rd_data, 32'd0);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 6000 && !ok; c++) begin
      @(posedge clk); #1;
      if (done) ok = 1'b1;
    end
  endtask

  task automatic load_vec(input int v);
    r_vals = vecs[v].vals; r_ovf = vecs[v].ovf; r_skip = vecs[v].skip;
  endtask

  task automatic run_vec(input int v, input bit abuse);
    int  bm_base, done_base;
    bit  ok, order_ok;
    logic [31:0] exp_bank;
    load_vec(v);
    noise_en = abuse;
    bm_base = bm_cnt; done_base = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    if (abuse) begin
      repeat (10) @(posedge clk); #1;
      chk("done_row_no_advance_row", 32'(row_select), 32'd0);
      chk("done_row_no_advance_cnt", 32'(bm_cnt - bm_base), 32'd1);
      start = 1'b1; @(posedge clk); #1; start = 1'b0;
    end
    wait_done(ok);
    chk("done_seen", 32'(ok), 32'd1);
    chk("busy_during_done", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("busy_after_done", 32'(busy), 32'd0);
    repeat (2) @(posedge clk); #1;
    chk("done_pulse_count", 32'(done_cnt - done_base), 32'd1);
    chk("begin_mult_count", 32'(bm_cnt - bm_base), 32'(NR));
    order_ok = 1'b1;
    for (int i = 0; i < NR; i++)
      if (bm_log[bm_base + i] !== 4'(i)) order_ok = 1'b0;
    chk("row_order", 32'(order_ok), 32'd1);
    chk("digit", 32'(digit), 32'(vecs[v].exp_digit));
    chk("max_value", max_value, vecs[v].exp_max);
    chk("overflow_any", 32'(overflow_any), 32'(vecs[v].exp_ovf));
    chk("timeout_err", 32'(timeout_err), 32'(vecs[v].exp_tmo));
    for (int a = 0; a < NR; a++) begin
      rd_addr = 4'(a); @(negedge clk);
      exp_bank = vecs[v].skip[a] ? 32'd0 : vecs[v].vals[a];
      chk($sformatf("bank[%0d]", a), rd_data, exp_bank);
    end
    rd_addr = 4'd12; @(negedge clk);
    chk("bank_out_of_range", rd_data, 32'd0);
    $display("sweep vec=%0d abuse=%0d digit=%0d max=%h ovf=%0b tmo=%0b", v, abuse, digit,
             max_value, overflow_any, timeout_err);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int  bm_base, done_base;
    bit  ok;
    // Vector table
    for (int r = 0; r < NR; r++) begin
      vecs[0].vals[r] = 32'(100 * r);
      vecs[2].vals[r] = -32'(r + 1);
      vecs[3].vals[r] = 32'(10 * r + 1);
    end
    vecs[0].ovf = '0; vecs[0].skip = '0;
    vecs[0].exp_digit = 4'd9; vecs[0].exp_max = 32'd900; vecs[0].exp_ovf = 0; vecs[0].exp_tmo = 0;

    vecs[1].vals[0] = -32'd5;  vecs[1].vals[1] = -32'd1; vecs[1].vals[2] = 32'd7;
    vecs[1].vals[3] = 32'd7;   vecs[1].vals[4] = 32'h8000_0000; vecs[1].vals[5] = 32'd0;
    vecs[1].vals[6] = 32'd3;   vecs[1].vals[7] = 32'd7; vecs[1].vals[8] = -32'd9;
    vecs[1].vals[9] = 32'd2;
    vecs[1].ovf = '0; vecs[1].skip = '0;
    vecs[1].exp_digit = 4'd2; vecs[1].exp_max = 32'd7; vecs[1].exp_ovf = 0; vecs[1].exp_tmo = 0;

    vecs[2].ovf = '0; vecs[2].skip = '0;
    vecs[2].exp_digit = 4'd0; vecs[2].exp_max = 32'hFFFF_FFFF; vecs[2].exp_ovf = 0; vecs[2].exp_tmo = 0;

    vecs[3].vals[6] = 32'd5000;
    vecs[3].ovf = 10'b00_0001_0000; vecs[3].skip = 10'b00_0100_0000;
    vecs[3].exp_digit = 4'd9; vecs[3].exp_max = 32'd91; vecs[3].exp_ovf = 1; vecs[3].exp_tmo = 1;

    load_vec(0);

    // Reset state
    repeat (3) @(posedge clk); #1;
    check_reset_state("reset");
    n_rst = 1'b1;

    // Table-driven sweeps
    for (int v = 0; v < 4; v++) run_vec(v, 1'b0);

    // Protocol abuse: done_row noise, start while busy, then strobes in IDLE
    run_vec(0, 1'b1);
    noise_en = 1'b0;
    @(posedge clk); #1;
    poke_req = poke_req + 1;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(posedge clk); #1;
      if (poke_ack == poke_req) ok = 1'b1;
    end
    chk("idle_poke_done", 32'(ok), 32'd1);
    chk("idle_strobe_busy", 32'(busy), 32'd0);
    chk("idle_strobe_digit", 32'(digit), 32'd9);
    chk("idle_strobe_ovf", 32'(overflow_any), 32'd0);
    for (int a = 0; a < NR; a++) begin
      rd_addr = 4'(a); @(negedge clk);
      chk($sformatf("idle_bank[%0d]", a), rd_data, 32'(100 * a));
    end
    $display("idle strobe burst applied, bank rechecked");

    // Reset in the middle of row 5's wait
    load_vec(0);
    bm_base = bm_cnt; done_base = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 1000 && !ok; c++) begin
      @(posedge clk); #1;
      if (bm_cnt - bm_base >= 6) ok = 1'b1;
    end
    chk("reach_row5", 32'(ok), 32'd1);
    chk("row5_select", 32'(row_select), 32'd5);
    repeat (5) @(posedge clk); #1;
    n_rst = 1'b0;
    @(posedge clk); #1;
    check_reset_state("midreset");
    n_rst = 1'b1;
    repeat (40) @(posedge clk); #1;
    chk("midreset_no_done", 32'(done_cnt - done_base), 32'd0);
    rd_addr = 4'd5; @(negedge clk);
    chk("midreset_bank5", rd_data, 32'd0);
    $display("mid-sweep reset applied at row 5");
    run_vec(0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
